uart_boot_loader: RTL

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_pkg.sv | 17 +
 rtl/uart_boot_loader_if.sv | 14 +
 rtl/uart_rx_byte.sv | 81 ++++++++
 rtl/uart_boot_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encodings,
// the image magic word and the autobaud/timeout constants.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    BAUD, SKIP, MAGIC, LEN, DATA, WRITE, DONE, ERR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_phase_t;

  localparam logic [31:0] MAGIC_WORD   = 32'h4341_4645;  // "CAFE"
  localparam int          MIN_PERIOD   = 8;
  localparam int          TIMEOUT_MULT = 64;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Memory write port of the boot loader. mem_we is "valid", mem_ack is "ready":
// a word transfers on a rising edge where both are high, and while mem_we is
// high without mem_ack the master holds mem_addr/mem_wdata/mem_we stable.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_ack;

    modport master (output mem_addr, mem_wdata, mem_we, input mem_ack);
    modport slave  (input mem_addr, mem_wdata, mem_we, output mem_ack);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver timed by a measured bit period: samples start at P/2,
// data bits every P after that, then the stop bit.
module uart_rx_byte
    import uart_boot_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             rx,
    input  logic [CNT_W-1:0] period,
    output logic [7:0]       data,
    output logic             valid,
    output logic             frame_err,
    output rx_phase_t        phase
);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] half;

    assign half = period >> 1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!en) begin
                phase <= RX_IDLE;
            end else begin
                case (phase)
                    RX_IDLE: begin
                        if (!rx) begin
                            phase <= RX_START;
                            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    RX_START: begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (cnt == half) begin
                            phase   <= rx ? RX_IDLE : RX_DATA;
                            bit_idx <= '0;
                            cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt == period) begin
                            data    <= {rx, data[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
                            if (bit_idx == 3'd7) phase <= RX_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt == period) begin
                            valid     <= rx;
                            frame_err <= !rx;
                            phase     <= RX_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: phase <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: autobauds on a 0xFF frame, checks the magic word, takes a
// word count and writes the image to memory while holding the core in reset.
// Define UART_BOOT_TIMEOUT_EN to add an idle-line timeout during the load.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int                CNT_W     = 16,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               uart_rx,
    uart_boot_loader_if.master mem,
    output logic               core_hold,
    output logic               boot_done,
    output logic               boot_err,
    output boot_state_t        dbg_state,
    output rx_phase_t          dbg_rx_phase,
    output logic [CNT_W-1:0]   dbg_period
);

    logic              rx_s1, rx_s2, rx_d;
    boot_state_t       state;
    logic [CNT_W-1:0]  period, tmr;
    logic              measuring;
    logic [2:0]        skip_bits;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [31:0]       n_words, word_idx, buf_word, wdata_q;
    logic              buf_full, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        byte_data;
    logic              byte_valid, frame_err, rx_en, word_done;
    logic [31:0]       word;
    rx_phase_t         rx_phase;

`ifdef UART_BOOT_TIMEOUT_EN
    logic [CNT_W+5:0]  idle_cnt, timeout_limit;
    assign timeout_limit = (CNT_W+6)'(TIMEOUT_MULT) * {6'd0, period};
`endif

    assign rx_en     = state inside {MAGIC, LEN, DATA, WRITE};
    assign word_done = byte_valid && (byte_cnt == 2'd3);
    assign word      = {shift, byte_data};

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign dbg_state     = state;
    assign dbg_rx_phase  = rx_phase;
    assign dbg_period    = period;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    uart_rx_byte #(.CNT_W(CNT_W)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .en        (rx_en),
        .rx        (rx_s2),
        .period    (period),
        .data      (byte_data),
        .valid     (byte_valid),
        .frame_err (frame_err),
        .phase     (rx_phase)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= BAUD;
            period    <= '0;
            tmr       <= '0;
            measuring <= 1'b0;
            skip_bits <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            buf_full  <= 1'b0;
            buf_word  <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            core_hold <= 1'b1;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
`ifdef UART_BOOT_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            if (byte_valid) begin
                shift    <= {shift[15:0], byte_data};
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (frame_err) begin
                state    <= ERR;
                boot_err <= 1'b1;
                we_q     <= 1'b0;
            end else begin
                case (state)
                    BAUD: begin
                        // Width of the 0xFF start bit is the bit period.
                        if (!measuring) begin
                            if (rx_d && !rx_s2) begin
                                measuring <= 1'b1;
                                tmr       <= {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else if (!rx_s2) begin
                            if (tmr != '1) tmr <= tmr + 1'b1;
                        end else begin
                            measuring <= 1'b0;
                            if (tmr >= CNT_W'(MIN_PERIOD) && tmr != '1) begin
                                period    <= tmr;
                                tmr       <= {{(CNT_W-1){1'b0}}, 1'b1};
                                skip_bits <= '0;
                                state     <= SKIP;
                            end
                        end
                    end
                    SKIP: begin
                        // Let the 8 high data bits pass; we leave inside the stop bit.
                        if (tmr == period) begin
                            tmr       <= {{(CNT_W-1){1'b0}}, 1'b1};
                            skip_bits <= skip_bits + 1'b1;
                            if (skip_bits == 3'd7) state <= MAGIC;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    MAGIC: begin
                        if (word_done) begin
                            if (word == MAGIC_WORD) begin
                                state <= LEN;
                            end else begin
                                state    <= ERR;
                                boot_err <= 1'b1;
                            end
                        end
                    end
                    LEN: begin
                        if (word_done) begin
                            if (word == '0) begin
                                state     <= DONE;
                                boot_done <= 1'b1;
                                core_hold <= 1'b0;
                            end else if (word > 32'(MAX_WORDS)) begin
                                state    <= ERR;
                                boot_err <= 1'b1;
                            end else begin
                                n_words <= word;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // A buffered word goes first; a word landing the same cycle refills the buffer.
                        if (buf_full || word_done) begin
                            we_q     <= 1'b1;
                            addr_q   <= BASE_ADDR + ADDR_W'({word_idx, 2'b00});
                            wdata_q  <= buf_full ? buf_word : word;
                            buf_full <= buf_full && word_done;
                            buf_word <= word;
                            state    <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (word_done) begin
                            buf_full <= 1'b1;
                            buf_word <= word;
                        end
                        if (word_done && buf_full) begin
                            state    <= ERR;
                            boot_err <= 1'b1;
                            we_q     <= 1'b0;
                        end else if (mem.mem_ack) begin
                            we_q     <= 1'b0;
                            word_idx <= word_idx + 32'd1;
                            if (word_idx + 32'd1 == n_words) begin
                                state     <= DONE;
                                boot_done <= 1'b1;
                                core_hold <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    default: ;
                endcase
`ifdef UART_BOOT_TIMEOUT_EN
                if (state inside {SKIP, MAGIC, LEN, DATA} && rx_phase == RX_IDLE) begin
                    if (idle_cnt >= timeout_limit) begin
                        state    <= ERR;
                        boot_err <= 1'b1;
                        we_q     <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt <= '0;
                end
`endif
            end
        end
    end

endmodule
